// File: rtl/cipher_stream_rx_if.sv
// Handshake and serial bus bundle for cipher_stream_rx.
// The slave modport is the receiver's view; the master modport is the
// serializer and byte-consumer side. state_dbg exposes the receiver FSM
// (0 = IDLE, 1 = RECV).
interface cipher_stream_rx_if #(
    parameter int MSG_SIZE = 512
);
    localparam int CW = $clog2(MSG_SIZE / 8) + 1;

    logic          ena;
    logic          iSerial_out;
    logic          iSerial_start;
    logic          iSerial_end;
    logic          iReady;
    logic [7:0]    oData;
    logic          oValid;
    logic          oFrame_done;
    logic          oFrame_err;
    logic [CW-1:0] oByte_count;
    logic          state_dbg;

    modport master (
        output ena, iSerial_out, iSerial_start, iSerial_end, iReady,
        input  oData, oValid, oFrame_done, oFrame_err, oByte_count, state_dbg
    );

    modport slave (
        input  ena, iSerial_out, iSerial_start, iSerial_end, iReady,
        output oData, oValid, oFrame_done, oFrame_err, oByte_count, state_dbg
    );
endinterface

// File: rtl/cipher_stream_rx.sv
// cipher_stream_rx: deserializes a ciphertext bit stream (MSB first) into
// bytes and queues them in a small FIFO for a valid/ready consumer.
// Handshake: a byte transfers on every rising edge where oValid and iReady
// are both high; oData holds steady while oValid is high and iReady is low.
// Optional feature macro: CIPHER_RX_LEN_CHECK_EN flags frames whose bit
// count differs from MSG_SIZE.
module cipher_stream_rx #(
    parameter int MSG_SIZE   = 512,
    parameter int FIFO_DEPTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    cipher_stream_rx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MSG_SIZE / 8) + 1;

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] byte_cnt;
    logic          frame_done;
    logic          frame_err;
    logic          clr_pending;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;

    logic          capture, fresh, abort, closing, byte_done;
    logic          full, empty, pop, push_ok, drop, len_err, err_set;
    logic [2:0]    bits_before;
    logic [7:0]    byte_next;

    // Per-cycle decode of what the incoming bit does to the frame and FIFO.
    always_comb begin
        empty       = (wp == rp);
        full        = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        pop         = !empty && bus.iReady;
        fresh       = bus.ena && bus.iSerial_start;
        abort       = fresh && (state == RECV);
        capture     = bus.ena && ((state == RECV) || bus.iSerial_start);
        bits_before = fresh ? 3'd0 : bit_cnt;
        byte_next   = {shreg[6:0], bus.iSerial_out};
        byte_done   = capture && (bits_before == 3'd7);
        closing     = capture && bus.iSerial_end;
        push_ok     = byte_done && (!full || pop);
        drop        = byte_done && full && !pop;
        err_set     = drop || (closing && !byte_done) || len_err;
    end

`ifdef CIPHER_RX_LEN_CHECK_EN
    localparam int TW = $clog2(MSG_SIZE) + 2;
    logic [TW-1:0] tot_bits, tot_before, tot_now;

    // Total frame length, saturating so oversize frames never alias MSG_SIZE.
    always_comb begin
        tot_before = fresh ? '0 : tot_bits;
        tot_now    = (&tot_before) ? tot_before : tot_before + 1'b1;
        len_err    = closing && (tot_now != TW'(MSG_SIZE));
    end

    // Frame length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_bits <= '0;
        end else if (capture) begin
            tot_bits <= tot_now;
        end
    end
`else
    assign len_err = 1'b0;
`endif

    // Frame FSM with bit assembly, byte count and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            clr_pending <= 1'b0;
        end else begin
            frame_done <= closing;
            if (capture) begin
                shreg   <= byte_next;
                bit_cnt <= closing ? 3'd0 : 3'(bits_before + 3'd1);
                state   <= closing ? IDLE : RECV;
            end
            if (fresh) begin
                byte_cnt <= '0;
            end else if (push_ok) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            // An aborted frame shows its error for exactly one cycle.
            if (abort) begin
                frame_err   <= 1'b1;
                clr_pending <= 1'b1;
            end else if (fresh || clr_pending) begin
                frame_err   <= err_set;
                clr_pending <= 1'b0;
            end else begin
                frame_err   <= frame_err | err_set;
            end
        end
    end

    // FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
        end
    end

    // FIFO storage; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[AW-1:0]] <= byte_next;
    end

    assign bus.oValid      = !empty;
    assign bus.oData       = empty ? 8'h00 : mem[rp[AW-1:0]];
    assign bus.oFrame_done = frame_done;
    assign bus.oFrame_err  = frame_err;
    assign bus.oByte_count = byte_cnt;
    assign bus.state_dbg   = (state == RECV);
endmodule
